// File: rtl/ysyx_22050039_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050039_decode_stage_if
// Description : Bundle of the decode stage's IFU-side handshake, EXU-side
//               handshake, write-back port and flush. The slave modport is
//               the decode stage; the master modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22050039_decode_stage_if #(
    parameter int XLEN     = 64,
    parameter int REG_SEL  = 5,
    parameter int INST_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [INST_LEN-1:0] in_inst;
    logic [XLEN-1:0]     in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_src1;
    logic [XLEN-1:0]     out_src2;
    logic [XLEN-1:0]     out_imm;
    logic [REG_SEL-1:0]  out_rd;
    logic [5:0]          out_type;
    logic [4:0]          out_opcode;
    logic [2:0]          out_funct3;
    logic                out_funct7b5;
    logic                out_wen;
    logic                out_wpc;
    logic                out_ebreak;
    logic                out_illegal;

    logic                wb_valid;
    logic [REG_SEL-1:0]  wb_rd;
    logic [XLEN-1:0]     wb_data;

    logic                flush;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        output in_ready, out_valid, out_pc, out_src1, out_src2, out_imm, out_rd,
               out_type, out_opcode, out_funct3, out_funct7b5, out_wen, out_wpc,
               out_ebreak, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        input  in_ready, out_valid, out_pc, out_src1, out_src2, out_imm, out_rd,
               out_type, out_opcode, out_funct3, out_funct7b5, out_wen, out_wpc,
               out_ebreak, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050039_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050039_decode_stage
// Description : RV64 instruction decode stage. Owns the GPR file with a
//               write-back bypass, stalls RAW/WAW hazards with a per-register
//               busy scoreboard and hands decoded fields to the EXU through a
//               registered valid/ready stage that can be flushed.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050039_decode_stage #(
    parameter int XLEN     = 64,
    parameter int NR_REG   = 32,
    parameter int REG_SEL  = 5,
    parameter int INST_LEN = 32
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    ysyx_22050039_decode_stage_if.slave    bus
);
    // one-hot instruction format, ordered {R,I,S,B,U,J}
    localparam logic [5:0] c_type_r = 6'b100000;
    localparam logic [5:0] c_type_i = 6'b010000;
    localparam logic [5:0] c_type_s = 6'b001000;
    localparam logic [5:0] c_type_b = 6'b000100;
    localparam logic [5:0] c_type_u = 6'b000010;
    localparam logic [5:0] c_type_j = 6'b000001;
    // formats that write rd: R, I, U, J
    localparam logic [5:0] c_writes_rd = 6'b110011;
    localparam logic [31:0] c_ebreak = 32'h0010_0073;

    logic [INST_LEN-1:0] w_inst;
    logic [6:0]          w_opc;
    logic [REG_SEL-1:0]  w_rs1, w_rs2, w_rd;
    logic [5:0]          w_type;
    logic [XLEN-1:0]     w_imm;
    logic                w_use1, w_use2, w_wpc, w_ebreak, w_illegal, w_wen;
    logic [XLEN-1:0]     w_src1, w_src2;
    logic                w_hazard, w_in_ready, w_capture;
    logic [NR_REG-1:0]   w_busy_nxt;

    logic [XLEN-1:0]     r_gpr [NR_REG];
    logic [NR_REG-1:0]   r_busy;

    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_pc, r_out_src1, r_out_src2, r_out_imm;
    logic [REG_SEL-1:0]  r_out_rd;
    logic [5:0]          r_out_type;
    logic [4:0]          r_out_opcode;
    logic [2:0]          r_out_funct3;
    logic                r_out_funct7b5, r_out_wen, r_out_wpc, r_out_ebreak, r_out_illegal;

    assign w_inst = bus.in_inst;
    assign w_opc  = w_inst[6:0];
    assign w_rd   = w_inst[11:7];
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];

    // Format, operand usage and immediate decode from the opcode
    always_comb begin
        w_type    = 6'b0;
        w_imm     = '0;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        w_wpc     = 1'b0;
        w_ebreak  = 1'b0;
        w_illegal = 1'b0;
        case (w_opc)
            7'b0110111, 7'b0010111: begin
                w_type = c_type_u;
                w_imm  = {{(XLEN-32){w_inst[31]}}, w_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                w_type = c_type_j;
                w_wpc  = 1'b1;
                w_imm  = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20],
                          w_inst[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin
                w_type = c_type_i;
                w_use1 = 1'b1;
                w_wpc  = (w_opc == 7'b1100111);
                w_imm  = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
            end
            7'b0100011: begin
                w_type = c_type_s;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_imm  = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            7'b1100011: begin
                w_type = c_type_b;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_wpc  = 1'b1;
                w_imm  = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25],
                          w_inst[11:8], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                w_type = c_type_r;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            7'b1110011: begin
                // only ebreak is implemented among SYSTEM encodings
                if (w_inst == c_ebreak) w_ebreak  = 1'b1;
                else                    w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_wen = (|(w_type & c_writes_rd)) && (w_rd != '0);

    // Operand read with same-cycle write-back bypass; unused operands read 0
    always_comb begin
        w_src1 = '0;
        w_src2 = '0;
        if (w_use1 && w_rs1 != '0)
            w_src1 = (bus.wb_valid && bus.wb_rd == w_rs1) ? bus.wb_data : r_gpr[w_rs1];
        if (w_use2 && w_rs2 != '0)
            w_src2 = (bus.wb_valid && bus.wb_rd == w_rs2) ? bus.wb_data : r_gpr[w_rs2];
    end

    // A busy register stalls unless its write-back lands this very cycle
    always_comb begin
        w_hazard = 1'b0;
        if (bus.in_valid) begin
            if (w_use1 && r_busy[w_rs1] && !(bus.wb_valid && bus.wb_rd == w_rs1))
                w_hazard = 1'b1;
            if (w_use2 && r_busy[w_rs2] && !(bus.wb_valid && bus.wb_rd == w_rs2))
                w_hazard = 1'b1;
            if (w_wen && r_busy[w_rd] && !(bus.wb_valid && bus.wb_rd == w_rd))
                w_hazard = 1'b1;
        end
    end

    assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;
    assign w_capture  = bus.in_valid && w_in_ready;

    // Scoreboard next state: clears first, so a same-index set wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_valid)
            w_busy_nxt[bus.wb_rd] = 1'b0;
        if (bus.flush && r_out_valid && r_out_wen &&
            !(bus.wb_valid && bus.wb_rd == r_out_rd))
            w_busy_nxt[r_out_rd] = 1'b0;
        if (w_capture && w_wen)
            w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) r_gpr[i] <= '0;
        end else if (bus.wb_valid && bus.wb_rd != '0) begin
            r_gpr[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Output stage: flush kills, capture loads, consume empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_src1     <= '0;
            r_out_src2     <= '0;
            r_out_imm      <= '0;
            r_out_rd       <= '0;
            r_out_type     <= '0;
            r_out_opcode   <= '0;
            r_out_funct3   <= '0;
            r_out_funct7b5 <= 1'b0;
            r_out_wen      <= 1'b0;
            r_out_wpc      <= 1'b0;
            r_out_ebreak   <= 1'b0;
            r_out_illegal  <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid    <= 1'b1;
            r_out_pc       <= bus.in_pc;
            r_out_src1     <= w_src1;
            r_out_src2     <= w_src2;
            r_out_imm      <= w_imm;
            r_out_rd       <= w_rd;
            r_out_type     <= w_type;
            r_out_opcode   <= w_inst[6:2];
            r_out_funct3   <= w_inst[14:12];
            r_out_funct7b5 <= w_inst[30];
            r_out_wen      <= w_wen;
            r_out_wpc      <= w_wpc;
            r_out_ebreak   <= w_ebreak;
            r_out_illegal  <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_pc       = r_out_pc;
    assign bus.out_src1     = r_out_src1;
    assign bus.out_src2     = r_out_src2;
    assign bus.out_imm      = r_out_imm;
    assign bus.out_rd       = r_out_rd;
    assign bus.out_type     = r_out_type;
    assign bus.out_opcode   = r_out_opcode;
    assign bus.out_funct3   = r_out_funct3;
    assign bus.out_funct7b5 = r_out_funct7b5;
    assign bus.out_wen      = r_out_wen;
    assign bus.out_wpc      = r_out_wpc;
    assign bus.out_ebreak   = r_out_ebreak;
    assign bus.out_illegal  = r_out_illegal;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050039_decode_stage
// Description : Directed self-checking bench for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050039_decode_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050039_decode_stage_if bus ();

    ysyx_22050039_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [63:0] d);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        wb(1'b0, 5'd0, 64'h0);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        #12;
        check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst_out_imm",   bus.out_imm, 64'd0);
        check("rst_out_rd",    {59'b0, bus.out_rd}, 64'd0);
        check("rst_busy",      {32'b0, dut.r_busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

        // addi x1,x0,5
        drive(1'b1, 32'h0050_0093, 64'h8000_0000);
        #1 check("addi_in_ready", {63'b0, bus.in_ready}, 64'd1);
        step();
        check("addi_valid", {63'b0, bus.out_valid}, 64'd1);
        check("addi_type",  {58'b0, bus.out_type}, 64'h10);
        check("addi_imm",   bus.out_imm, 64'd5);
        check("addi_rd",    {59'b0, bus.out_rd}, 64'd1);
        check("addi_wen",   {63'b0, bus.out_wen}, 64'd1);
        check("addi_pc",    bus.out_pc, 64'h8000_0000);
        check("addi_busy1", {63'b0, dut.r_busy[1]}, 64'd1);

        // add x2,x1,x1 stalls on busy x1
        drive(1'b1, 32'h0010_8133, 64'h8000_0004);
        #1 check("raw_stall", {63'b0, bus.in_ready}, 64'd0);
        step();
        check("raw_drained", {63'b0, bus.out_valid}, 64'd0);
        check("raw_busy_hold", {63'b0, dut.r_busy[1]}, 64'd1);
        wb(1'b1, 5'd1, 64'd5);
        #1 check("raw_unstall", {63'b0, bus.in_ready}, 64'd1);
        step();
        wb(1'b0, 5'd0, 64'd0);
        drive(1'b0, 32'h0, 64'h0);
        check("add_valid", {63'b0, bus.out_valid}, 64'd1);
        check("add_src1",  bus.out_src1, 64'd5);
        check("add_src2",  bus.out_src2, 64'd5);
        check("add_type",  {58'b0, bus.out_type}, 64'h20);
        check("add_busy1", {63'b0, dut.r_busy[1]}, 64'd0);
        check("add_busy2", {63'b0, dut.r_busy[2]}, 64'd1);
        wb(1'b1, 5'd2, 64'd10);
        step();
        wb(1'b0, 5'd0, 64'd0);
        check("add_consumed", {63'b0, bus.out_valid}, 64'd0);

        // back-pressure: hold A for three cycles while B waits
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0010_0293, 64'h100);
        step();
        drive(1'b1, 32'h0020_0313, 64'h104);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
            step();
            check("bp_hold_rd",  {59'b0, bus.out_rd}, 64'd5);
            check("bp_hold_imm", bus.out_imm, 64'd1);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release", {63'b0, bus.in_ready}, 64'd1);
        step();
        check("bp_b_rd", {59'b0, bus.out_rd}, 64'd6);
        check("bp_b_pc", bus.out_pc, 64'h104);
        drive(1'b1, 32'h0030_0393, 64'h108);
        step();
        check("bp_c_rd",  {59'b0, bus.out_rd}, 64'd7);
        check("bp_c_imm", bus.out_imm, 64'd3);
        drive(1'b0, 32'h0, 64'h0);
        step();
        check("bp_empty", {63'b0, bus.out_valid}, 64'd0);
        wb(1'b1, 5'd5, 64'd1); step();
        wb(1'b1, 5'd6, 64'd2); step();
        wb(1'b1, 5'd7, 64'd3); step();
        wb(1'b0, 5'd0, 64'd0);

        // immediate formats
        drive(1'b1, 32'hFFDF_F06F, 64'h200);
        step();
        check("jal_imm",  bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("jal_type", {58'b0, bus.out_type}, 64'h01);
        check("jal_wpc",  {63'b0, bus.out_wpc}, 64'd1);
        check("jal_wen",  {63'b0, bus.out_wen}, 64'd0);
        drive(1'b1, 32'hFE00_0EE3, 64'h204);
        step();
        check("beq_imm",  bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_type", {58'b0, bus.out_type}, 64'h04);
        drive(1'b1, 32'h8000_00B7, 64'h208);
        step();
        check("lui_imm",  bus.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_type", {58'b0, bus.out_type}, 64'h02);
        check("lui_rd",   {59'b0, bus.out_rd}, 64'd1);
        drive(1'b0, 32'h0, 64'h0);
        wb(1'b1, 5'd1, 64'h1234);
        step();
        wb(1'b0, 5'd0, 64'd0);
        check("lui_wb_busy1", {63'b0, dut.r_busy[1]}, 64'd0);

        // flush while holding addi x3
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0070_0193, 64'h300);
        step();
        check("fl_hold_busy3", {63'b0, dut.r_busy[3]}, 64'd1);
        drive(1'b0, 32'h0, 64'h0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("fl_valid", {63'b0, bus.out_valid}, 64'd0);
        check("fl_busy3", {63'b0, dut.r_busy[3]}, 64'd0);

        // capture and write-back to the same rd: set wins
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0090_0193, 64'h304);
        wb(1'b1, 5'd3, 64'h55);
        step();
        drive(1'b0, 32'h0, 64'h0);
        wb(1'b0, 5'd0, 64'd0);
        check("setwin_busy3", {63'b0, dut.r_busy[3]}, 64'd1);
        check("setwin_imm",   bus.out_imm, 64'd9);
        wb(1'b1, 5'd3, 64'h66);
        step();
        wb(1'b0, 5'd0, 64'd0);

        // illegal with rd=1 and ebreak
        drive(1'b1, 32'h0000_0080, 64'h400);
        step();
        check("ill_flag",  {63'b0, bus.out_illegal}, 64'd1);
        check("ill_wen",   {63'b0, bus.out_wen}, 64'd0);
        check("ill_type",  {58'b0, bus.out_type}, 64'd0);
        check("ill_busy1", {63'b0, dut.r_busy[1]}, 64'd0);
        drive(1'b1, 32'h0010_0073, 64'h404);
        step();
        check("ebreak_flag", {63'b0, bus.out_ebreak}, 64'd1);
        check("ebreak_ill",  {63'b0, bus.out_illegal}, 64'd0);

        // write-back to x0 is ignored, also by the bypass
        drive(1'b1, 32'h0000_8433, 64'h408);
        wb(1'b1, 5'd0, 64'hDEAD);
        step();
        wb(1'b0, 5'd0, 64'd0);
        check("x0_src1_x1", bus.out_src1, 64'h1234);
        check("x0_src2",    bus.out_src2, 64'd0);
        drive(1'b1, 32'h0000_04B3, 64'h40C);
        step();
        drive(1'b0, 32'h0, 64'h0);
        check("x0_reads_zero", bus.out_src1, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
